// File: rtl/lsu_queue_pkg.sv
// Shared constants for the load/store queue: size codes, memctrl flags, FSM
// states, and the byte-count, alignment and load-extension helpers.
package lsu_queue_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Size code 3 is illegal and behaves as a word everywhere.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      SZ_WORD: is_misaligned = (lo != 2'b00);
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                              input logic uns);
    case (size)
      SZ_BYTE: load_extend = uns ? {24'd0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: load_extend = uns ? {16'd0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      SZ_WORD: load_extend = raw;
      default: load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_queue_req_fifo.sv
// Circular request buffer for the load/store queue. Holds one operation per
// entry plus a live flag that a misbranch clears on loads.
module lsu_req_fifo
  import lsu_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic              kill_loads,
  input  logic              push_we,
  input  logic [1:0]        push_size,
  input  logic              push_unsigned,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [TAG_W-1:0]  push_tag,
  output logic              head_we,
  output logic [1:0]        head_size,
  output logic              head_unsigned,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [TAG_W-1:0]  head_tag,
  output logic              head_live,
  output logic [CW-1:0]     count
);

  logic              we_r   [DEPTH];
  logic [1:0]        size_r [DEPTH];
  logic              uns_r  [DEPTH];
  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [TAG_W-1:0]  tag_r  [DEPTH];
  logic              live_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  // Storage, pointers and occupancy; everything freezes while en is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        live_r[i] <= 1'b0;
      end
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_loads && !we_r[i]) begin
          live_r[i] <= 1'b0;
        end
      end
      if (push) begin
        we_r[wr_ptr_r]   <= push_we;
        size_r[wr_ptr_r] <= push_size;
        uns_r[wr_ptr_r]  <= push_unsigned;
        addr_r[wr_ptr_r] <= push_addr;
        data_r[wr_ptr_r] <= push_data;
        tag_r[wr_ptr_r]  <= push_tag;
        // A load arriving alongside a flush is born dead.
        live_r[wr_ptr_r] <= push_we || !kill_loads;
        wr_ptr_r         <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_we       = we_r[rd_ptr_r];
  assign head_size     = size_r[rd_ptr_r];
  assign head_unsigned = uns_r[rd_ptr_r];
  assign head_addr     = addr_r[rd_ptr_r];
  assign head_data     = data_r[rd_ptr_r];
  assign head_tag      = tag_r[rd_ptr_r];
  assign head_live     = live_r[rd_ptr_r];
  assign count         = count_r;

endmodule

// File: rtl/lsu_queue.sv
// Buffered load/store unit: in-order queue, single-outstanding memctrl issue,
// load extension and CDB broadcast. LSU_ALIGN_CHECK_EN adds misalignment traps.
module lsu_queue
  import lsu_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data
`ifdef LSU_ALIGN_CHECK_EN
  ,output logic             cdb_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t            state_r, state_n;
  logic              push_s, pop_s, issue_s, retire_s, trap_s;
  logic              head_we_s, head_uns_s, head_live_s;
  logic [1:0]        head_size_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;
  logic [TAG_W-1:0]  head_tag_s;
  logic [CW-1:0]     count_s;

  assign in_ready = rdy && (count_s != FULL_CNT);
  assign push_s   = in_valid && in_ready;

  lsu_req_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .en           (rdy),
    .push         (push_s),
    .pop          (pop_s),
    .kill_loads   (flush),
    .push_we      (in_we),
    .push_size    (in_size),
    .push_unsigned(in_unsigned),
    .push_addr    (in_addr),
    .push_data    (in_data),
    .push_tag     (in_tag),
    .head_we      (head_we_s),
    .head_size    (head_size_s),
    .head_unsigned(head_uns_s),
    .head_addr    (head_addr_s),
    .head_data    (head_data_s),
    .head_tag     (head_tag_s),
    .head_live    (head_live_s),
    .count        (count_s)
  );

  // Next-state and per-cycle actions on the queue head.
  always_comb begin
    state_n  = state_r;
    pop_s    = 1'b0;
    issue_s  = 1'b0;
    retire_s = 1'b0;
    trap_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_s == {CW{1'b0}}) begin
          state_n = ST_IDLE;
        end else if (!head_live_s || (flush && !head_we_s)) begin
          pop_s = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        end else if (is_misaligned(head_size_s, head_addr_s[1:0])) begin
          pop_s  = 1'b1;
          trap_s = 1'b1;
`endif
        end else begin
          issue_s = 1'b1;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          pop_s    = 1'b1;
          retire_s = !head_we_s && head_live_s && !flush;
          state_n  = ST_IDLE;
        end else begin
          state_n = ST_WAIT;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else if (rdy) begin
      state_r <= state_n;
    end
  end

  // Registered memctrl request and CDB broadcast.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= 3'd0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      cdb_valid <= 1'b0;
      cdb_tag   <= {TAG_W{1'b0}};
      cdb_data  <= {DATA_W{1'b0}};
`ifdef LSU_ALIGN_CHECK_EN
      cdb_err   <= 1'b0;
`endif
    end else if (rdy) begin
      mem_en    <= issue_s;
      cdb_valid <= retire_s || trap_s;
`ifdef LSU_ALIGN_CHECK_EN
      cdb_err   <= trap_s;
`endif
      if (issue_s) begin
        mem_we    <= head_we_s ? MEM_WRITE : MEM_READ;
        mem_size  <= size_bytes(head_size_s);
        mem_addr  <= head_addr_s;
        mem_wdata <= head_data_s;
      end
      if (retire_s || trap_s) begin
        cdb_tag  <= head_tag_s;
        cdb_data <= trap_s ? {DATA_W{1'b0}} : load_extend(mem_rdata, head_size_s, head_uns_s);
      end
    end
  end

endmodule

// File: doc/lsu_queue.md
# lsu_queue

Parametrised, buffered load/store unit between the load/store buffer (LSB) and the memory controller. It accepts up to DEPTH memory operations into an in-order request queue and issues them one at a time to memctrl. It sign- or zero-extends load data and broadcasts tagged results on the CDB. On a misbranch it kills pending and in-flight loads, while issued stores always complete.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- ADDR_W, 32: address width
- DATA_W, 32: data width; fixed at 32 for RV32 sizes
- TAG_W, 4: ROB tag width carried to the CDB
- clk  in  1  clock; one clock domain, all logic on posedge
- rst  in  1  reset; synchronous, active-low
- rdy  in  1  global enable; low = hold all state
- in_valid  in  1  LSB offers an operation
- in_ready  out  1  queue can accept; = rdy && count<DEPTH
- in_we  in  1  1 = store, 0 = load
- in_size  in  2  0 byte, 1 half, 2 word; 3 is illegal and is treated as word
- in_unsigned  in  1  load zero-extension (LBU/LHU)
- in_addr  in  ADDR_W  effective address
- in_data  in  DATA_W  store data, low bytes significant
- in_tag  in  TAG_W  ROB tag
- flush  in  1  misbranch; kill loads
- mem_en  out  1  one-cycle request pulse to memctrl
- mem_we  out  1  write flag
- mem_size  out  3  byte count 1/2/4
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  store data
- mem_done  in  1  one-cycle completion pulse
- mem_rdata  in  DATA_W  load data; valid with mem_done
- cdb_valid  out  1  one-cycle result pulse
- cdb_tag  out  TAG_W  result tag
- cdb_data  out  DATA_W  extended load result
- cdb_err  out  1  misaligned access; present only with the macro

## Operation
- Queue entries hold {we, size, unsigned, addr, data, tag, live}. Push occurs on in_valid && in_ready.
- FSM states:
  - IDLE: if the head is present and live, register the request, assert mem_en, go to WAIT. If the head is dead, pop it; this takes 1 cycle and makes no memory access.
  - WAIT: mem_en is 0. On mem_done, pop the head and return to IDLE.
- Load completion:
  - cdb_valid=1 with the head tag.
  - cdb_data: byte or half is sign- or zero-extended per in_unsigned; word passes unchanged.
  - Stores never drive the CDB, except on an error with the macro enabled.
- Flush:
  - Clears live on every queued load, including a load being pushed in the same cycle.
  - Stores stay live.
  - An in-flight load in WAIT is marked dead. The memory transaction runs to mem_done, then the entry is popped with no CDB pulse.
  - mem_done and flush on the same edge: the load result is suppressed.
- Push and pop may occur on the same edge; count is unchanged.

## Timing
- Reset values:
  - All outputs are 0, except in_ready, which follows rdy.
  - FSM = IDLE, count = 0, pointers = 0.
- rdy low: no register changes, in_ready=0, mem_done ignored (memctrl is also stalled).
- Issue latency: an entry pushed at edge T into an empty queue has mem_en high in cycle T+1 to T+2 (issued at edge T+1).
- Result latency: mem_done at edge D gives cdb_valid high for exactly the cycle after D.
- Throughput: at most one memory operation outstanding. In steady state the next issue happens 1 cycle after mem_done.
- Full: in_ready=0 when count==DEPTH, even if a pop happens that cycle (no bypass).
- Reset mid-transaction: everything is cleared. memctrl is reset by the same rst.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - At IDLE issue, a half with addr[0]≠0 or a word with addr[1:0]≠0 is misaligned.
  - A misaligned access makes no memory request; the entry is popped immediately.
  - The next cycle gives cdb_valid=1, cdb_err=1, cdb_data=0, and cdb_tag set to the entry tag, for both loads and stores.
  - If the entry is dead, no pulse is produced.
- LSU_ALIGN_CHECK_EN undefined:
  - The cdb_err port does not exist.
  - Addresses pass unchanged; memctrl handles any alignment.

## Structure
- Size encodings, the mem_size mapping (0→1, 1→2, 2→4), FSM state values and the READ/WRITE flags live in the shared constant header.
- Sub-module lsu_req_fifo holds the circular buffer:
  - Ports: push, pop, head outputs, count, kill_loads.
  - Contents: log2(DEPTH) pointers, wrap-around at DEPTH-1→0, count of width log2(DEPTH)+1.
- The FSM and extension logic sit in lsu_queue.

## Test plan
- LB at 0x100, tag 3, mem_rdata=0x000000F0 → cdb_valid pulse, tag 3, data 0xFFFFFFF0. The same with LBU gives 0x000000F0.
- Push 4 operations back-to-back (DEPTH=4) with memory stalled → in_ready=0 on the 5th. After one mem_done, in_ready returns to 1. Issue order is FIFO.
- Queue SW tag1, LW tag2, LH tag3, then flush while SW is in WAIT → SW completes at the memory, tags 2 and 3 produce no CDB pulse, and the queue drains to empty.
- LW in WAIT with flush and mem_done on the same edge → no cdb_valid; the next queued store issues 1 cycle later.
- rdy low for 3 cycles mid-WAIT with in_valid=1 → no push and no output change; operation resumes identically.
- With LSU_ALIGN_CHECK_EN: LW at 0x102, tag 5 → no mem_en; cdb_err=1, tag 5, data 0. SH at 0x200 → normal write with mem_size=2.
